// File: rtl/alu_decoder_pkg.sv
// alu_decoder_pkg: shared constants, select codes and the decoded-entry
// type for the RV32I OP / OP-IMM front end of the 32-bit alu.
package alu_decoder_pkg;

    // Major opcodes handled by the decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 values shared by OP and OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 values: base encoding and the alternate (sub) encoding
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Select codes understood by the alu
    typedef enum logic [3:0] {
        SEL_ADD  = 4'h0,
        SEL_SUB  = 4'h1,
        SEL_AND  = 4'h2,
        SEL_OR   = 4'h4,
        SEL_XOR  = 4'h6,
        SEL_SLL  = 4'h8,
        SEL_SRL  = 4'hA,
        SEL_SLT  = 4'hC,
        SEL_SLTU = 4'hE
    } alu_sel_e;

    // One decoded instruction as carried through the output stage
    typedef struct packed {
        alu_sel_e    select;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [31:0] imm;
        logic        illegal;
    } dec_entry_t;

    localparam dec_entry_t DEC_ENTRY_ZERO = '0;

    // Base-encoding funct3 to alu select (funct3 000 maps to add)
    function automatic alu_sel_e funct3_to_sel(input logic [2:0] f3);
        alu_sel_e sel;
        case (f3)
            F3_ADD:  sel = SEL_ADD;
            F3_SLL:  sel = SEL_SLL;
            F3_SLT:  sel = SEL_SLT;
            F3_SLTU: sel = SEL_SLTU;
            F3_XOR:  sel = SEL_XOR;
            F3_SRL:  sel = SEL_SRL;
            F3_OR:   sel = SEL_OR;
            F3_AND:  sel = SEL_AND;
            default: sel = SEL_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder_core.sv
// alu_decoder_core: purely combinational decode of one RV32I word into a
// dec_entry_t. OP-IMM support is present only when ALU_DECODER_IMM_EN is
// defined; otherwise OP-IMM words are reported illegal.
module alu_decoder_core
    import alu_decoder_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_entry_t  o_entry
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Word-to-entry decode; illegal words carry only the register fields
    always_comb begin
        o_entry         = DEC_ENTRY_ZERO;
        o_entry.rd      = i_instr[11:7];
        o_entry.rs1     = i_instr[19:15];
        o_entry.rs2     = i_instr[24:20];
        o_entry.illegal = 1'b1;
        case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == F7_BASE) begin
                    o_entry.select  = funct3_to_sel(w_funct3);
                    o_entry.illegal = 1'b0;
                end else if ((w_funct7 == F7_ALT) && (w_funct3 == F3_ADD)) begin
                    o_entry.select  = SEL_SUB;
                    o_entry.illegal = 1'b0;
                end else begin
                    // sra and any other funct7 variant are not supported
                    o_entry.illegal = 1'b1;
                end
            end
`ifdef ALU_DECODER_IMM_EN
            OPC_OP_IMM: begin
                if ((w_funct3 == F3_SLL) || (w_funct3 == F3_SRL)) begin
                    if (w_funct7 == F7_BASE) begin
                        o_entry.select  = funct3_to_sel(w_funct3);
                        o_entry.use_imm = 1'b1;
                        o_entry.imm     = {27'b0, i_instr[24:20]};
                        o_entry.illegal = 1'b0;
                    end else begin
                        // srai and malformed shift-immediates
                        o_entry.illegal = 1'b1;
                    end
                end else begin
                    o_entry.select  = funct3_to_sel(w_funct3);
                    o_entry.use_imm = 1'b1;
                    o_entry.imm     = {{20{i_instr[31]}}, i_instr[31:20]};
                    o_entry.illegal = 1'b0;
                end
            end
`endif
            default: begin
                o_entry.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder: valid/ready front end for the alu. Decodes RV32I OP (and,
// with ALU_DECODER_IMM_EN defined, OP-IMM) words through one output
// register backed by a one-entry skid buffer, and counts illegal words
// with a saturating CNT_W-bit counter.
module alu_decoder
    import alu_decoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_select,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_use_imm,
    output logic [31:0]      out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_entry_t       w_dec;
    logic             w_in_fire;
    logic             w_out_load;

    dec_entry_t       r_out;
    logic             r_out_valid;
    dec_entry_t       r_skid;
    // High when the skid buffer is empty; doubles as the registered in_ready
    logic             r_skid_empty;
    logic [CNT_W-1:0] r_illegal_cnt;

    alu_decoder_core u_core (
        .i_instr (in_instr),
        .o_entry (w_dec)
    );

    assign w_in_fire  = in_valid && r_skid_empty;
    // Output register may take a new value when empty or being drained
    assign w_out_load = !r_out_valid || out_ready;

    // Output register and skid buffer; skid drains before new words enter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out        <= DEC_ENTRY_ZERO;
            r_out_valid  <= 1'b0;
            r_skid       <= DEC_ENTRY_ZERO;
            r_skid_empty <= 1'b1;
        end else begin
            if (w_out_load) begin
                if (!r_skid_empty) begin
                    // in_ready is low while the skid is full, so no new word arrives now
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_empty <= 1'b1;
                end else if (w_in_fire) begin
                    r_out       <= w_dec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                // Output stalled: park the accepted word so out_* stays stable
                r_skid       <= w_dec;
                r_skid_empty <= 1'b0;
            end
        end
    end

    // Saturating count of accepted illegal words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= {CNT_W{1'b0}};
        end else if (w_in_fire && w_dec.illegal && (r_illegal_cnt != CNT_MAX)) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_ONE;
        end
    end

    assign in_ready    = r_skid_empty;
    assign out_valid   = r_out_valid;
    assign out_select  = r_out.select;
    assign out_rd      = r_out.rd;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_use_imm = r_out.use_imm;
    assign out_imm     = r_out.imm;
    assign out_illegal = r_out.illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: directed scoreboard bench for alu_decoder (CNT_W = 4).
// Expected entries are queued when a word is accepted and compared when
// the decoder hands the entry downstream.
module tb_alu_decoder;

    localparam int CNT_W = 4;
`ifdef ALU_DECODER_IMM_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_instr = 32'h0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [3:0]       out_select;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic             out_use_imm;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    typedef struct packed {
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    exp_t             obs;
    exp_t             e1, e2, e3;
    int               n_assert = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    assign obs = {out_select, out_rd, out_rs1, out_rs2, out_use_imm, out_imm, out_illegal};

    alu_decoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_select  (out_select),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_use_imm (out_use_imm),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
        n_assert++;
        assert (o === x) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, x);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [3:0] sel,
                                input logic use_imm, input logic [31:0] imm, input logic ill);
        mk = {sel, instr[11:7], instr[19:15], instr[24:20], use_imm, imm, ill};
    endfunction

    function automatic exp_t mk_ill(input logic [31:0] instr);
        mk_ill = mk(instr, 4'h0, 1'b0, 32'h0, 1'b1);
    endfunction

    // OP-IMM words decode only when the immediate path is built in
    function automatic exp_t mk_imm(input logic [31:0] instr, input logic [3:0] sel,
                                    input logic [31:0] imm);
        if (IMM_EN) mk_imm = mk(instr, sel, 1'b1, imm, 1'b0);
        else        mk_imm = mk_ill(instr);
    endfunction

    task automatic send(input logic [31:0] instr, input exp_t e);
        int waited = 0;
        in_valid = 1'b1;
        in_instr = instr;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("accept", {63'b0, in_ready}, 64'd1);
        if (in_ready) begin
            sb_q.push_back(e);
            if (e.ill && exp_cnt != {CNT_W{1'b1}}) exp_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    // Scoreboard: an entry leaves the DUT at the next edge when valid && ready
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_assert++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_empty: observed %h expected no output", obs);
            end
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("decode", 64'(obs), 64'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        check("rst_fields", 64'(obs), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // add, sub, addi, slli, srai
        send(32'h002081B3, mk(32'h002081B3, 4'h0, 1'b0, 32'h0, 1'b0));
        send(32'h402081B3, mk(32'h402081B3, 4'h1, 1'b0, 32'h0, 1'b0));
        send(32'hFFF00093, mk_imm(32'hFFF00093, 4'h0, 32'hFFFFFFFF));
        send(32'h00431293, mk_imm(32'h00431293, 4'h8, 32'h00000004));
        send(32'h4030D093, mk_ill(32'h4030D093));
        drain();
        check("cnt_after_srai", 64'(illegal_cnt), 64'(exp_cnt));

        // Remaining OP functions, sra, and immediate sign handling
        send(32'h002091B3, mk(32'h002091B3, 4'h8, 1'b0, 32'h0, 1'b0));
        send(32'h0020A1B3, mk(32'h0020A1B3, 4'hC, 1'b0, 32'h0, 1'b0));
        send(32'h0020B1B3, mk(32'h0020B1B3, 4'hE, 1'b0, 32'h0, 1'b0));
        send(32'h0020C1B3, mk(32'h0020C1B3, 4'h6, 1'b0, 32'h0, 1'b0));
        send(32'h0020D1B3, mk(32'h0020D1B3, 4'hA, 1'b0, 32'h0, 1'b0));
        send(32'h0020E1B3, mk(32'h0020E1B3, 4'h4, 1'b0, 32'h0, 1'b0));
        send(32'h0020F1B3, mk(32'h0020F1B3, 4'h2, 1'b0, 32'h0, 1'b0));
        send(32'h4020D1B3, mk_ill(32'h4020D1B3));
        send(32'h0FF0F093, mk_imm(32'h0FF0F093, 4'h2, 32'h000000FF));
        send(32'h80016113, mk_imm(32'h80016113, 4'h4, 32'hFFFFF800));
        drain();
        check("cnt_after_ops", 64'(illegal_cnt), 64'(exp_cnt));

        // Backpressure: first word held, second in skid, third stalled
        e1 = mk(32'h002081B3, 4'h0, 1'b0, 32'h0, 1'b0);
        e2 = mk(32'h0020C1B3, 4'h6, 1'b0, 32'h0, 1'b0);
        e3 = mk(32'h0020E1B3, 4'h4, 1'b0, 32'h0, 1'b0);
        out_ready = 1'b0;
        send(32'h002081B3, e1);
        send(32'h0020C1B3, e2);
        in_valid = 1'b1;
        in_instr = 32'h0020E1B3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {63'b0, in_ready}, 64'd0);
            check("stall_out_valid", {63'b0, out_valid}, 64'd1);
            check("stall_hold", 64'(obs), 64'(e1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h0020E1B3, e3);
        drain();

        // Reset during a stall, with a nonzero illegal count
        out_ready = 1'b0;
        send(32'h002081B3, mk(32'h002081B3, 4'h0, 1'b0, 32'h0, 1'b0));
        send(32'h4020D1B3, mk_ill(32'h4020D1B3));
        in_valid = 1'b1;
        in_instr = 32'h0020E1B3;
        @(negedge clk);
        check("pre_rst_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'b0, out_valid}, 64'd0);
        check("arst_in_ready", {63'b0, in_ready}, 64'd1);
        check("arst_cnt", 64'(illegal_cnt), 64'd0);
        check("arst_fields", 64'(obs), 64'd0);
        sb_q.delete();
        exp_cnt = '0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h002081B3, mk(32'h002081B3, 4'h0, 1'b0, 32'h0, 1'b0));
        drain();
        check("post_rst_cnt", 64'(illegal_cnt), 64'd0);

        // Counter saturation: 20 illegal loads (opcode 0x03)
        for (int i = 0; i < 20; i++) begin
            logic [31:0] w;
            w = 32'h00002003 | (32'(i) << 7);
            send(w, mk_ill(w));
        end
        drain();
        check("cnt_saturate", 64'(illegal_cnt), 64'(exp_cnt));
        check("cnt_saturate_max", 64'(illegal_cnt), 64'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_decoder.md
# alu_decoder

Instruction-side front end for the 32-bit `alu`. It accepts RV32I register-register (OP) and register-immediate (OP-IMM) instruction words over a valid/ready handshake. It produces the `alu` 4-bit `select` code, register indices and the operand-B immediate, through one registered pipeline stage with a skid buffer. It also flags unsupported encodings and keeps a saturating count of them for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the illegal-instruction counter.

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_instr` is valid.
- `in_ready` out 1: decoder can accept a word.
- `in_instr` in 32: RV32I instruction word.
- `out_valid` out 1: decoded fields are valid.
- `out_ready` in 1: downstream accepts them.
- `out_select` out 4: `alu` select code.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: register indices, taken from bits [11:7], [19:15] and [24:20].
- `out_use_imm` out 1: operand B is `out_imm`, not rs2.
- `out_imm` out 32: operand-B immediate.
- `out_illegal` out 1: the word is not a supported ALU op.
- `illegal_cnt` out `CNT_W`: count of illegal words accepted.

## Operation
- Input transfer: a word is transferred when `in_valid && in_ready`.
- Output transfer: a decoded entry is transferred when `out_valid && out_ready`.
- Select codes:
  - add 0x0, sub 0x1, and 0x2, or 0x4, xor 0x6.
  - sll 0x8, srl 0xA, slt 0xC, sltu 0xE.
- OP decode (opcode 0110011), by funct3:
  - 000 gives add when funct7 = 0000000 and sub when funct7 = 0100000.
  - 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
  - Any other funct7 value is illegal; this includes sra.
  - `out_use_imm` = 0.
- OP-IMM decode (opcode 0010011), by funct3:
  - Same funct3 map as OP; funct3 000 is always add.
  - `out_use_imm` = 1.
  - `out_imm` is sign-extended `in_instr[31:20]`.
  - For funct3 001/101 (shifts), funct7 must be 0000000, otherwise the word is illegal (this excludes srai). `out_imm` = {27'b0, `in_instr[24:20]`}.
- Illegal words:
  - Trigger: any other opcode, or an illegal funct7.
  - The word is still issued with `out_illegal` = 1, `out_select` = 0x0, `out_use_imm` = 0 and `out_imm` = 0. Register fields pass through.
- Illegal counter: `illegal_cnt` increments on the input transfer of an illegal word and saturates at all-ones.

## Timing
- Latency: an accepted word appears on `out_*` on the next cycle.
- Throughput: one word per cycle while `out_ready` = 1.
- Structure: one output register plus a one-entry skid buffer.
  - `in_ready` = NOT skid_valid, driven directly from a flop.
  - If `out_valid && !out_ready` and a word is accepted, that word goes to the skid buffer.
  - When the output register drains, the skid entry moves to the output register; `in_ready` rises the following cycle.
- Stability: while `out_valid && !out_ready`, every `out_*` field holds stable.
- Simultaneous accept and drain: with the skid buffer empty, output is taken and a new word is accepted in the same cycle. The output register loads the new word and `out_valid` stays 1.
- Reset (asynchronous, at any time, including mid-transfer):
  - Pipeline and skid entries are discarded.
  - `out_valid` = 0 and all `out_*` fields = 0.
  - `illegal_cnt` = 0.
  - `in_ready` = 1.
  - The first accept is possible on the first rising edge after `rst_n` deasserts.

## Configuration
- `ALU_DECODER_IMM_EN` defined: OP-IMM is decoded as above.
- `ALU_DECODER_IMM_EN` undefined: OP-IMM words are illegal, and `out_use_imm` and `out_imm` are tied to 0.

## Structure
- Package `alu_decoder_pkg` holds:
  - The opcode constants (OP, OP-IMM).
  - The funct3/funct7 constants.
  - The nine `alu` select codes.
  - The decoded-entry struct: select, rd, rs1, rs2, use_imm, imm, illegal.
- Sub-module `alu_decoder_core`: purely combinational word-to-entry decode. The top level holds the handshake, output register, skid buffer and counter.

## Test plan
- add: 0x002081B3, `out_ready` = 1 → next cycle `out_select` = 0x0, rd = 3, rs1 = 1, rs2 = 2, `out_use_imm` = 0, `out_illegal` = 0.
- sub then addi, back-to-back: 0x402081B3 then 0xFFF00093 → select 0x1, then select 0x0 with `out_imm` = 0xFFFFFFFF and `out_use_imm` = 1, on consecutive cycles.
- slli then srai:
  - 0x00431293 → select 0x8, `out_imm` = 0x00000004, rd = 5.
  - 0x4030D093 → `out_illegal` = 1, select 0x0, `illegal_cnt` = 1.
- Backpressure: stream three words with `out_ready` = 0.
  - First word is held on `out_*`, second goes to the skid buffer, `in_ready` = 0 and the third is stalled.
  - Raise `out_ready`: all three emerge in order with none lost or duplicated.
- Reset mid-stall: assert `rst_n` = 0 asynchronously during the backpressure case → `out_valid` = 0, `in_ready` = 1 and `illegal_cnt` = 0 immediately. After release, a fresh add decodes normally.
- Counter saturation (`CNT_W` = 4): 20 illegal words (opcode 0x03) → `illegal_cnt` stops at 15.
